range_scan_reader: RTL and testbench

RANGE_SCAN_READER -- requirements
Module: range_scan_reader

---
 rtl/range_pkg.sv | 19 +
 rtl/range_cmp.sv | 15 +
 rtl/range_scan_reader.sv | 152 +++++++++++++++
 tb/tb_range_scan_reader.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/range_pkg.sv
// Types shared by the range-table scan reader and the range-table writer.
// Holds the entry layout, the default table geometry and the reader FSM states.
package range_pkg;

    localparam int SIZE_DEF  = 32;
    localparam int IDX_W_DEF = 5;

    typedef struct packed {
        logic [31:0] first;
        logic [31:0] last;
    } range_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/range_cmp.sv
// Inclusive unsigned containment test: first <= addr <= last.
// An inverted entry (first > last) can never satisfy both bounds, so it never matches.
module range_cmp
    import range_pkg::*;
(
    input  logic [31:0] addr,
    input  range_t      rng,
    output logic        in_range
);

    always_comb begin
        in_range = (addr >= rng.first) && (addr <= rng.last);
    end

endmodule

// File: rtl/range_scan_reader.sv
// Looks up an address in a range table by scanning one entry per cycle from index 0,
// reporting the first entry whose inclusive bounds contain the address.
module range_scan_reader
    import range_pkg::*;
#(
    parameter int SIZE  = SIZE_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [31:0]      req_addr_i,
    input  logic [IDX_W:0]   tbl_count_i,
    output logic [IDX_W-1:0] tbl_idx_o,
    input  logic [31:0]      tbl_first_i,
    input  logic [31:0]      tbl_last_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic             rsp_hit_o,
    output logic [IDX_W-1:0] rsp_idx_o,
    output logic [31:0]      rsp_first_o,
    output logic [31:0]      rsp_last_o
);

    localparam logic [IDX_W:0] SIZE_CNT = (IDX_W+1)'(SIZE);

    state_e           state;
    state_e           state_nxt;
    logic [IDX_W-1:0] idx;
    logic [31:0]      addr_q;
    logic [IDX_W:0]   cnt_q;
    logic [IDX_W:0]   cnt_clamp;
    range_t           entry;
    logic             in_range;
    logic             match;
    logic             scan_end;

    logic             rsp_hit_q;
    logic [IDX_W-1:0] rsp_idx_q;
    logic [31:0]      rsp_first_q;
    logic [31:0]      rsp_last_q;

    always_comb begin
        cnt_clamp = (tbl_count_i > SIZE_CNT) ? SIZE_CNT : tbl_count_i;
    end

    assign entry = '{first: tbl_first_i, last: tbl_last_i};

    range_cmp u_cmp (
        .addr     (addr_q),
        .rng      (entry),
        .in_range (in_range)
    );

    // An empty table still spends one SCAN cycle, so every miss answers after max(N,1) edges.
    always_comb begin
        match    = (state == ST_SCAN) && (cnt_q != '0) && in_range;
        scan_end = (({1'b0, idx} + (IDX_W+1)'(1)) >= cnt_q);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (req_valid_i)        state_nxt = ST_SCAN;
            ST_SCAN: if (match || scan_end)  state_nxt = ST_RESP;
            ST_RESP: if (rsp_ready_i)        state_nxt = ST_IDLE;
            default:                         state_nxt = ST_IDLE;
        endcase
        if (flush_i) begin
            state_nxt = ST_IDLE;
        end
    end

    always_comb begin
        req_ready_o = (state == ST_IDLE);
        rsp_valid_o = (state == ST_RESP);
        tbl_idx_o   = (state == ST_SCAN) ? idx : '0;
    end

    // Response registers are only non-zero while a hit is being presented.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            idx         <= '0;
            addr_q      <= '0;
            cnt_q       <= '0;
            rsp_hit_q   <= 1'b0;
            rsp_idx_q   <= '0;
            rsp_first_q <= '0;
            rsp_last_q  <= '0;
        end else if (flush_i) begin
            idx         <= '0;
            rsp_hit_q   <= 1'b0;
            rsp_idx_q   <= '0;
            rsp_first_q <= '0;
            rsp_last_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        addr_q      <= req_addr_i;
                        cnt_q       <= cnt_clamp;
                        idx         <= '0;
                        rsp_hit_q   <= 1'b0;
                        rsp_idx_q   <= '0;
                        rsp_first_q <= '0;
                        rsp_last_q  <= '0;
                    end
                end
                ST_SCAN: begin
                    if (match) begin
                        rsp_hit_q   <= 1'b1;
                        rsp_idx_q   <= idx;
                        rsp_first_q <= tbl_first_i;
                        rsp_last_q  <= tbl_last_i;
                        idx         <= '0;
                    end else if (scan_end) begin
                        idx <= '0;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_hit_q   <= 1'b0;
                        rsp_idx_q   <= '0;
                        rsp_first_q <= '0;
                        rsp_last_q  <= '0;
                    end
                end
                default: begin
                    idx <= '0;
                end
            endcase
        end
    end

    assign rsp_hit_o   = rsp_hit_q;
    assign rsp_idx_o   = rsp_idx_q;
    assign rsp_first_o = rsp_first_q;
    assign rsp_last_o  = rsp_last_q;

endmodule

// File: tb/tb_range_scan_reader.sv
// Bench for range_scan_reader: a transaction-level lookup model checked every cycle,
// plus directed lookups with hand-computed results, latencies and control scenarios.
module tb_range_scan_reader;

    localparam int SIZE  = 32;
    localparam int IDX_W = 5;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic             flush_i = 1'b0;
    logic             req_valid_i = 1'b0;
    logic             req_ready_o;
    logic [31:0]      req_addr_i = '0;
    logic [IDX_W:0]   tbl_count_i = '0;
    logic [IDX_W-1:0] tbl_idx_o;
    logic [31:0]      tbl_first_i;
    logic [31:0]      tbl_last_i;
    logic             rsp_valid_o;
    logic             rsp_ready_i = 1'b0;
    logic             rsp_hit_o;
    logic [IDX_W-1:0] rsp_idx_o;
    logic [31:0]      rsp_first_o;
    logic [31:0]      rsp_last_o;

    logic [31:0] firsts [SIZE];
    logic [31:0] lasts  [SIZE];

    range_scan_reader #(.SIZE(SIZE), .IDX_W(IDX_W)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_addr_i  (req_addr_i),
        .tbl_count_i (tbl_count_i),
        .tbl_idx_o   (tbl_idx_o),
        .tbl_first_i (tbl_first_i),
        .tbl_last_i  (tbl_last_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_hit_o   (rsp_hit_o),
        .rsp_idx_o   (rsp_idx_o),
        .rsp_first_o (rsp_first_o),
        .rsp_last_o  (rsp_last_o)
    );

    always #5 clk_i = ~clk_i;

    assign tbl_first_i = firsts[tbl_idx_o];
    assign tbl_last_i  = lasts[tbl_idx_o];

    typedef struct {
        bit          hit;
        int          idx;
        logic [31:0] first;
        logic [31:0] last;
        int          lat;
    } exp_t;

    // Whole-lookup answer: first containing entry among min(count,SIZE), and its latency in edges.
    function automatic exp_t lookup(input logic [31:0] a, input int n);
        exp_t r;
        int   nn;
        nn      = (n > SIZE) ? SIZE : n;
        r.hit   = 1'b0;
        r.idx   = 0;
        r.first = '0;
        r.last  = '0;
        r.lat   = (nn == 0) ? 1 : nn;
        for (int i = 0; i < nn; i++) begin
            if (!r.hit && firsts[i] <= a && a <= lasts[i]) begin
                r.hit   = 1'b1;
                r.idx   = i;
                r.first = firsts[i];
                r.last  = lasts[i];
                r.lat   = i + 1;
            end
        end
        return r;
    endfunction

    int   cyc   = 0;
    int   start = 0;
    bit   busy  = 1'b0;
    bit   armed = 1'b0;
    exp_t m;

    always @(posedge clk_i) begin
        cyc <= cyc + 1;
        if (!rst_ni) begin
            busy  <= 1'b0;
            armed <= 1'b1;
        end else if (flush_i) begin
            busy <= 1'b0;
        end else if (!busy && req_valid_i) begin
            busy  <= 1'b1;
            start <= cyc + 1;
            m     <= lookup(req_addr_i, int'(tbl_count_i));
        end else if (busy && cyc >= start + m.lat && rsp_ready_i) begin
            busy <= 1'b0;
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic compare();
        bit vis;
        bit scan;
        vis  = busy && (cyc >= start + m.lat);
        scan = busy && !vis;
        chk("req_ready", 32'(req_ready_o), 32'(!busy));
        chk("rsp_valid", 32'(rsp_valid_o), 32'(vis));
        chk("tbl_idx", 32'(tbl_idx_o), scan ? 32'(cyc - start) : 32'd0);
        chk("rsp_hit", 32'(rsp_hit_o), vis ? 32'(m.hit) : 32'd0);
        chk("rsp_idx", 32'(rsp_idx_o), vis ? 32'(m.idx) : 32'd0);
        chk("rsp_first", rsp_first_o, vis ? m.first : 32'd0);
        chk("rsp_last", rsp_last_o, vis ? m.last : 32'd0);
    endtask

    task automatic cycle();
        @(posedge clk_i);
        @(negedge clk_i);
        if (armed) compare();
    endtask

    task automatic drain();
        int n;
        n = 0;
        req_valid_i = 1'b0;
        flush_i     = 1'b0;
        rst_ni      = 1'b1;
        rsp_ready_i = 1'b1;
        while (!req_ready_o && n < 80) begin
            cycle();
            n++;
        end
        chk("drain_idle", 32'(req_ready_o), 32'd1);
        rsp_ready_i = 1'b0;
    endtask

    task automatic fill(input logic [31:0] f, input logic [31:0] l);
        for (int i = 0; i < SIZE; i++) begin
            firsts[i] = f;
            lasts[i]  = l;
        end
    endtask

    task automatic directed(input string name, input logic [31:0] a, input int cnt,
                            input bit eh, input int ei, input logic [31:0] ef,
                            input logic [31:0] el, input int elat);
        int n;
        flush_i     = 1'b0;
        rsp_ready_i = 1'b0;
        req_addr_i  = a;
        tbl_count_i = (IDX_W+1)'(cnt);
        req_valid_i = 1'b1;
        chk({name, "_accept_ready"}, 32'(req_ready_o), 32'd1);
        cycle();
        req_valid_i = 1'b0;
        req_addr_i  = $urandom;
        tbl_count_i = (IDX_W+1)'($urandom_range(0, 63));
        n = 0;
        while (!rsp_valid_o && n < 64) begin
            cycle();
            n++;
        end
        chk({name, "_latency"}, 32'(n), 32'(elat));
        chk({name, "_hit"}, 32'(rsp_hit_o), 32'(eh));
        chk({name, "_idx"}, 32'(rsp_idx_o), 32'(ei));
        chk({name, "_first"}, rsp_first_o, ef);
        chk({name, "_last"}, rsp_last_o, el);
        repeat (5) cycle();
        chk({name, "_held_valid"}, 32'(rsp_valid_o), 32'd1);
        chk({name, "_held_idx"}, 32'(rsp_idx_o), 32'(ei));
        chk({name, "_held_ready"}, 32'(req_ready_o), 32'd0);
        rsp_ready_i = 1'b1;
        cycle();
        rsp_ready_i = 1'b0;
        chk({name, "_back_idle"}, 32'(req_ready_o), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        fill(32'h10, 32'h20);
        rst_ni      = 1'b0;
        flush_i     = 1'b1;
        req_valid_i = 1'b1;
        cycle();
        cycle();
        chk("reset_ready", 32'(req_ready_o), 32'd1);
        chk("reset_valid", 32'(rsp_valid_o), 32'd0);
        chk("reset_tbl_idx", 32'(tbl_idx_o), 32'd0);
        chk("reset_first", rsp_first_o, 32'd0);
        rst_ni      = 1'b1;
        flush_i     = 1'b0;
        req_valid_i = 1'b0;
        cycle();

        firsts[0] = 32'h1000; lasts[0] = 32'h10FF;
        firsts[1] = 32'h2000; lasts[1] = 32'h20FF;
        directed("hit_e1", 32'h2080, 2, 1'b1, 1, 32'h2000, 32'h20FF, 2);
        directed("hit_top", 32'h10FF, 2, 1'b1, 0, 32'h1000, 32'h10FF, 1);
        directed("hit_bot", 32'h1000, 2, 1'b1, 0, 32'h1000, 32'h10FF, 1);
        directed("miss_gap", 32'h1100, 2, 1'b0, 0, 32'h0, 32'h0, 2);
        directed("count0", 32'h1050, 0, 1'b0, 0, 32'h0, 32'h0, 1);

        fill(32'h10, 32'h20);
        firsts[31] = 32'h7000; lasts[31] = 32'h70FF;
        directed("clamp_hit", 32'h7010, 40, 1'b1, 31, 32'h7000, 32'h70FF, 32);
        directed("clamp_miss", 32'h9000, 40, 1'b0, 0, 32'h0, 32'h0, 32);

        fill(32'h10, 32'h20);
        firsts[1] = 32'h3000; lasts[1] = 32'h2000;
        firsts[2] = 32'h100;  lasts[2] = 32'h200;
        directed("inverted", 32'h2800, 3, 1'b0, 0, 32'h0, 32'h0, 3);
        firsts[0] = 32'h2000; lasts[0] = 32'h2FFF;
        firsts[2] = 32'h2500; lasts[2] = 32'h2600;
        directed("overlap", 32'h2550, 3, 1'b1, 0, 32'h2000, 32'h2FFF, 1);

        fill(32'h10, 32'h20);
        req_addr_i  = 32'h5000;
        tbl_count_i = 6'd10;
        req_valid_i = 1'b1;
        cycle();
        req_valid_i = 1'b0;
        n = 0;
        while (tbl_idx_o != 5'd3 && n < 20) begin
            cycle();
            n++;
        end
        chk("flush_at_idx3", 32'(tbl_idx_o), 32'd3);
        flush_i = 1'b1;
        cycle();
        flush_i = 1'b0;
        chk("flush_idle", 32'(req_ready_o), 32'd1);
        chk("flush_no_rsp", 32'(rsp_valid_o), 32'd0);
        repeat (12) cycle();
        chk("flush_still_no_rsp", 32'(rsp_valid_o), 32'd0);

        req_addr_i  = 32'h15;
        tbl_count_i = 6'd1;
        req_valid_i = 1'b1;
        cycle();
        req_valid_i = 1'b0;
        n = 0;
        while (!rsp_valid_o && n < 10) begin
            cycle();
            n++;
        end
        chk("rstresp_hit_before", 32'(rsp_hit_o), 32'd1);
        rst_ni = 1'b0;
        cycle();
        chk("rstresp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rstresp_hit", 32'(rsp_hit_o), 32'd0);
        chk("rstresp_last", rsp_last_o, 32'd0);
        chk("rstresp_ready", 32'(req_ready_o), 32'd1);
        rst_ni = 1'b1;
        cycle();

        for (int ph = 0; ph < 4; ph++) begin
            drain();
            for (int i = 0; i < SIZE; i++) begin
                firsts[i] = 32'($urandom_range(0, 1000));
                if ($urandom_range(0, 7) == 0) lasts[i] = firsts[i] - 32'($urandom_range(1, 50));
                else                           lasts[i] = firsts[i] + 32'($urandom_range(0, 120));
            end
            for (int c = 0; c < 400; c++) begin
                req_valid_i = ($urandom_range(0, 2) != 0);
                req_addr_i  = 32'($urandom_range(0, 1200));
                tbl_count_i = (IDX_W+1)'($urandom_range(0, 40));
                rsp_ready_i = ($urandom_range(0, 2) == 0);
                flush_i     = ($urandom_range(0, 40) == 0);
                rst_ni      = ($urandom_range(0, 150) != 0);
                cycle();
            end
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
